regfile_operand_fetch: RTL and testbench

- Initiator/sequencer for the single-read-port, single-write-port CPU register file.
- Accepts an operand request with one or two source addresses and fetches them one per cycle through the file's read port.
- Read port: address sampled, data driven on negedge clk.
- Presents the captured operands on a valid/ready handshake.
- Drives the file's write port from the writeback stage and forwards same-cycle writes that the file's read would miss.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/opfetch_bypass.sv | 20 ++
 rtl/regfile_operand_fetch.sv | 131 +++++++++++++
 tb/tb_regfile_operand_fetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand-fetch FSM encoding and default register file geometry.
package cpu_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 4;
  localparam int unsigned RF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    HOLD = 2'd3
  } opfetch_state_e;

endpackage

// File: rtl/opfetch_bypass.sv
// Selects the writeback value over the file's read data when the write lands on the
// register being read in the same cycle (the file's negedge read cannot see it yet).
module opfetch_bypass #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] rf_radr_p,
  input  logic [DATA_WIDTH-1:0] rf_dout,
  output logic [DATA_WIDTH-1:0] fetch_data
);

  logic hit;

  assign hit        = wb_valid && (wb_adr == rf_radr_p);
  assign fetch_data = hit ? wb_data : rf_dout;

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch sequencer for a 1R/1W register file. Build option OPFETCH_DUP_SKIP_EN
// collapses a two-operand request with identical sources into a single read.
module regfile_operand_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs_a,
  input  logic [ADDR_WIDTH-1:0] req_rs_b,
  input  logic                  req_two,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] rf_radr_p,
  input  logic [DATA_WIDTH-1:0] rf_dout,
  output logic                  rf_we_p,
  output logic [ADDR_WIDTH-1:0] rf_wadr_n,
  output logic [DATA_WIDTH-1:0] rf_din
);

  opfetch_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0] rs_a_q, rs_a_d;
  logic [ADDR_WIDTH-1:0] rs_b_q, rs_b_d;
  logic                  two_q, two_d;
  logic [ADDR_WIDTH-1:0] radr_q, radr_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  dup_skip;

  // Writeback goes straight to the file; it commits at the next posedge.
  assign rf_we_p   = wb_valid;
  assign rf_wadr_n = wb_adr;
  assign rf_din    = wb_data;

  opfetch_bypass #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bypass (
    .wb_valid  (wb_valid),
    .wb_adr    (wb_adr),
    .wb_data   (wb_data),
    .rf_radr_p (radr_q),
    .rf_dout   (rf_dout),
    .fetch_data(fetch_data)
  );

`ifdef OPFETCH_DUP_SKIP_EN
  assign dup_skip = (rs_a_q == rs_b_q);
`else
  assign dup_skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rs_a_d  = rs_a_q;
    rs_b_d  = rs_b_q;
    two_d   = two_q;
    radr_d  = radr_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rs_a_d  = req_rs_a;
          rs_b_d  = req_rs_b;
          two_d   = req_two;
          radr_d  = req_rs_a;
          state_d = RD_A;
        end
      end
      RD_A: begin
        op_a_d = fetch_data;
        if (!two_q) begin
          op_b_d  = '0;
          state_d = HOLD;
        end else if (dup_skip) begin
          op_b_d  = fetch_data;
          state_d = HOLD;
        end else begin
          radr_d  = rs_b_q;
          state_d = RD_B;
        end
      end
      RD_B: begin
        op_b_d  = fetch_data;
        state_d = HOLD;
      end
      HOLD: begin
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rs_a_q  <= '0;
      rs_b_q  <= '0;
      two_q   <= 1'b0;
      radr_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      rs_a_q  <= rs_a_d;
      rs_b_q  <= rs_b_d;
      two_q   <= two_d;
      radr_q  <= radr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign op_valid  = (state_q == HOLD);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign rf_radr_p = radr_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed bench for regfile_operand_fetch with a behavioural 16x16 register file
// and a queue of expected operand results.
module tb_regfile_operand_fetch;

`ifdef OPFETCH_DUP_SKIP_EN
  localparam int DUP_LAT = 2;
`else
  localparam int DUP_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_rs_a = '0;
  logic [3:0]  req_rs_b = '0;
  logic        req_two = 1'b0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [15:0] op_a, op_b;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_adr = '0;
  logic [15:0] wb_data = '0;
  logic [3:0]  rf_radr_p;
  logic [15:0] rf_dout = '0;
  logic        rf_we_p;
  logic [3:0]  rf_wadr_n;
  logic [15:0] rf_din;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [15:0] mem [16];

  always #5 clk = ~clk;

  regfile_operand_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rs_a (req_rs_a),
    .req_rs_b (req_rs_b),
    .req_two  (req_two),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .wb_valid (wb_valid),
    .wb_adr   (wb_adr),
    .wb_data  (wb_data),
    .rf_radr_p(rf_radr_p),
    .rf_dout  (rf_dout),
    .rf_we_p  (rf_we_p),
    .rf_wadr_n(rf_wadr_n),
    .rf_din   (rf_din)
  );

  // Register file model: reset contents r0=1, writes on posedge, read on negedge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 16'h0001 : 16'h0000;
    end else if (rf_we_p) begin
      mem[rf_wadr_n] <= rf_din;
    end
  end

  always @(negedge clk) rf_dout <= mem[rf_radr_p];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [15:0] dat);
    wb_valid = 1'b1;
    wb_adr   = adr;
    wb_data  = dat;
    step();
    wb_valid = 1'b0;
  endtask

  // Issue one request; optionally drive a writeback in the cycle after accept edge wb_cyc.
  task automatic fetch(input logic [3:0] a, input logic [3:0] b, input logic two,
                       input logic [15:0] ea, input logic [15:0] eb, input int elat,
                       input int wb_cyc, input logic [3:0] wadr, input logic [15:0] wdat,
                       input bit release_op);
    exp_t e;
    int   k;
    sb.push_back('{a: ea, b: eb, lat: elat});
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_rs_a  = a;
    req_rs_b  = b;
    req_two   = two;
    step();
    req_valid = 1'b0;
    k = 1;
    wb_valid = (wb_cyc == 1);
    wb_adr   = wadr;
    wb_data  = wdat;
    while (!op_valid && k < 10) begin
      step();
      k++;
      wb_valid = (wb_cyc == k);
    end
    wb_valid = 1'b0;
    e = sb.pop_front();
    chk("op_valid_seen", {31'd0, op_valid}, 32'd1);
    chk("latency", k, e.lat);
    chk("op_a", {16'd0, op_a}, {16'd0, e.a});
    chk("op_b", {16'd0, op_b}, {16'd0, e.b});
    if (release_op) begin
      op_ready = 1'b1;
      step();
      op_ready = 1'b0;
      chk("op_valid_after_release", {31'd0, op_valid}, 32'd0);
      chk("req_ready_after_release", {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    #2;
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_op_a", {16'd0, op_a}, 32'd0);
    chk("rst_op_b", {16'd0, op_b}, 32'd0);
    chk("rst_radr", {28'd0, rf_radr_p}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    step();
    step();
    #3;
    reset = 1'b0;
    step();

    // Single operand from r0.
    fetch(4'd0, 4'd0, 1'b0, 16'h0001, 16'h0000, 2, 0, 4'd0, 16'h0, 1'b1);

    // Write committed before the request is read normally.
    wr(4'd3, 16'hBEEF);
    fetch(4'd3, 4'd0, 1'b1, 16'hBEEF, 16'h0001, 3, 0, 4'd0, 16'h0, 1'b1);

    // HOLD keeps snapshot while r3 is overwritten; op_b must clear for a one-operand request.
    fetch(4'd3, 4'd0, 1'b0, 16'hBEEF, 16'h0000, 2, 0, 4'd0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1;
      wb_adr   = 4'd3;
      wb_data  = 16'h0000;
      step();
      chk("hold_op_a", {16'd0, op_a}, 32'h0000BEEF);
      chk("hold_op_valid", {31'd0, op_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    wb_valid = 1'b0;
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    chk("hold_release_valid", {31'd0, op_valid}, 32'd0);
    chk("hold_release_ready", {31'd0, req_ready}, 32'd1);

    // Bypass in RD_B, then the write is visible from the file.
    fetch(4'd0, 4'd5, 1'b1, 16'h0001, 16'h1234, 3, 2, 4'd5, 16'h1234, 1'b1);
    fetch(4'd5, 4'd0, 1'b0, 16'h1234, 16'h0000, 2, 0, 4'd0, 16'h0, 1'b1);

    // Bypass in RD_A.
    fetch(4'd7, 4'd0, 1'b1, 16'h7777, 16'h0001, 3, 1, 4'd7, 16'h7777, 1'b1);

    // Identical sources.
    wr(4'd3, 16'hA5A5);
    fetch(4'd3, 4'd3, 1'b1, 16'hA5A5, 16'hA5A5, DUP_LAT, 0, 4'd0, 16'h0, 1'b1);

    // Reset while in RD_B drops the request.
    req_valid = 1'b1;
    req_rs_a  = 4'd5;
    req_rs_b  = 4'd7;
    req_two   = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("pre_rst_radr_b", {28'd0, rf_radr_p}, 32'd7);
    reset = 1'b1;
    #1;
    chk("mid_rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("mid_rst_op_a", {16'd0, op_a}, 32'd0);
    chk("mid_rst_op_b", {16'd0, op_b}, 32'd0);
    chk("mid_rst_radr", {28'd0, rf_radr_p}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_op_valid", {31'd0, op_valid}, 32'd0);
    step();
    fetch(4'd0, 4'd5, 1'b1, 16'h0001, 16'h0000, 3, 0, 4'd0, 16'h0, 1'b1);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
